// File: rtl/me_pkg.sv
// Shared constants, FSM encoding and width helper for the motion-estimation search control path.
package me_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REF,
        ST_FILL,
        ST_SEARCH,
        ST_REPORT
    } state_t;

    localparam int SAD_BIT_WIDTH  = 14;
    localparam int IDX_W          = 4;
    localparam int NUM_BATCHES    = 16;
    localparam int PIPE_LAT       = 3;
    localparam int BLOCKS_PER_ROW = 482;
    localparam int BLOCK_ROWS     = 270;
    localparam int EARLY_TERM_THR = 0;

    // Counter width that never collapses to zero bits for a count of one.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BATCH_W = cw(NUM_BATCHES);
    localparam int BLKX_W  = cw(BLOCKS_PER_ROW);
    localparam int BLKY_W  = cw(BLOCK_ROWS);

endpackage

// File: rtl/me_min_tracker.sv
// Running minimum of SAD with the batch/index that produced it; strict-less compare so the earliest tie wins.
// Clear has priority over update; one-cycle register update, no backpressure.
module me_min_tracker
    import me_pkg::*;
#(
    parameter int SW = SAD_BIT_WIDTH,
    parameter int BW = BATCH_W,
    parameter int IW = IDX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          upd,
    input  logic [SW-1:0] sad,
    input  logic [BW-1:0] batch,
    input  logic [IW-1:0] index,
    output logic [SW-1:0] min_sad,
    output logic [BW-1:0] min_batch,
    output logic [IW-1:0] min_index
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_sad   <= '1;
            min_batch <= '0;
            min_index <= '0;
        end else if (clr) begin
            min_sad   <= '1;
            min_batch <= '0;
            min_index <= '0;
        end else if (upd && (sad < min_sad)) begin
            min_sad   <= sad;
            min_batch <= batch;
            min_index <= index;
        end
    end

endmodule

// File: rtl/me_search_ctrl.sv
// Sequences one 8x8 block search per sram_ready, reports best SAD over valid/ready, then rasters to the next block.
// Result appears PIPE_LAT+NUM_BATCHES cycles after sram_ready; ME_EARLY_TERM_EN enables threshold early exit.
module me_search_ctrl #(
    parameter int SAD_BIT_WIDTH  = me_pkg::SAD_BIT_WIDTH,
    parameter int NUM_BATCHES    = me_pkg::NUM_BATCHES,
    parameter int PIPE_LAT       = me_pkg::PIPE_LAT,
    parameter int BLOCKS_PER_ROW = me_pkg::BLOCKS_PER_ROW,
    parameter int BLOCK_ROWS     = me_pkg::BLOCK_ROWS,
    localparam int BW = me_pkg::cw(NUM_BATCHES),
    localparam int XW = me_pkg::cw(BLOCKS_PER_ROW),
    localparam int YW = me_pkg::cw(BLOCK_ROWS),
    localparam int IW = me_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sram_ready,
    input  logic [SAD_BIT_WIDTH-1:0] MSAD_interim,
    input  logic [IW-1:0]            MSAD_index_interim,
    output logic                     blk_advance,
    output logic                     busy,
    output logic                     mv_valid,
    input  logic                     mv_ready,
    output logic [SAD_BIT_WIDTH-1:0] mv_sad,
    output logic [BW-1:0]            mv_batch,
    output logic [IW-1:0]            mv_index,
    output logic [XW-1:0]            blk_x,
    output logic [YW-1:0]            blk_y,
    output logic                     frame_done
);

    import me_pkg::*;

    localparam int FW = cw(PIPE_LAT);

    state_t                   state;
    logic [FW-1:0]            fill_cnt;
    logic [BW-1:0]            batch_cnt;
    logic [SAD_BIT_WIDTH-1:0] min_sad;
    logic [BW-1:0]            min_batch;
    logic [IW-1:0]            min_index;
    logic                     trk_clr;
    logic                     trk_upd;
    logic                     early_hit;
    logic                     last_blk;

    // The running min is held at all-ones whenever no block is in flight.
    assign trk_clr  = (state == ST_IDLE) || (state == ST_WAIT_REF);
    assign trk_upd  = (state == ST_SEARCH);
    assign last_blk = (blk_x == XW'(BLOCKS_PER_ROW - 1)) && (blk_y == YW'(BLOCK_ROWS - 1));

`ifdef ME_EARLY_TERM_EN
    // The min can only drop to the threshold through the incoming value itself.
    assign early_hit = (MSAD_interim <= SAD_BIT_WIDTH'(EARLY_TERM_THR));
`else
    assign early_hit = 1'b0;
`endif

    me_min_tracker #(
        .SW(SAD_BIT_WIDTH),
        .BW(BW),
        .IW(IW)
    ) u_min (
        .clk       (clk),
        .rst       (rst),
        .clr       (trk_clr),
        .upd       (trk_upd),
        .sad       (MSAD_interim),
        .batch     (batch_cnt),
        .index     (MSAD_index_interim),
        .min_sad   (min_sad),
        .min_batch (min_batch),
        .min_index (min_index)
    );

    assign mv_sad   = mv_valid ? min_sad   : '0;
    assign mv_batch = mv_valid ? min_batch : '0;
    assign mv_index = mv_valid ? min_index : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            fill_cnt    <= '0;
            batch_cnt   <= '0;
            blk_x       <= '0;
            blk_y       <= '0;
            busy        <= 1'b0;
            mv_valid    <= 1'b0;
            blk_advance <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            blk_advance <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WAIT_REF;
                        busy  <= 1'b1;
                        blk_x <= '0;
                        blk_y <= '0;
                    end
                end
                ST_WAIT_REF: begin
                    if (sram_ready) begin
                        fill_cnt  <= '0;
                        batch_cnt <= '0;
                        state     <= (PIPE_LAT > 1) ? ST_FILL : ST_SEARCH;
                    end
                end
                ST_FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == FW'(PIPE_LAT - 2)) begin
                        state <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    batch_cnt <= batch_cnt + 1'b1;
                    if (early_hit || (batch_cnt == BW'(NUM_BATCHES - 1))) begin
                        state    <= ST_REPORT;
                        mv_valid <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (mv_ready) begin
                        mv_valid    <= 1'b0;
                        blk_advance <= 1'b1;
                        if (last_blk) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            blk_x      <= '0;
                            blk_y      <= '0;
                        end else begin
                            state <= ST_WAIT_REF;
                            if (blk_x == XW'(BLOCKS_PER_ROW - 1)) begin
                                blk_x <= '0;
                                blk_y <= blk_y + 1'b1;
                            end else begin
                                blk_x <= blk_x + 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed + randomized bench for me_search_ctrl on a 3x2-block frame, with a loop-based reference model.
module tb_me_search_ctrl;
    import me_pkg::*;

    localparam int BPR = 3;
    localparam int BR  = 2;
    localparam int NB  = 16;
    localparam int PL  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sram_ready;
    logic        mv_ready;
    logic [13:0] MSAD_interim;
    logic [3:0]  MSAD_index_interim;
    logic        blk_advance;
    logic        busy;
    logic        mv_valid;
    logic        frame_done;
    logic [13:0] mv_sad;
    logic [3:0]  mv_batch;
    logic [3:0]  mv_index;
    logic [1:0]  blk_x;
    logic [0:0]  blk_y;

    int checks = 0;
    int errors = 0;
    int sad_v[NB];
    int idx_v[NB];
    int exp_x = 0;
    int exp_y = 0;
    int adv_cnt = 0;
    int exp_adv = 0;

    me_search_ctrl #(
        .BLOCKS_PER_ROW(BPR),
        .BLOCK_ROWS(BR)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .sram_ready         (sram_ready),
        .MSAD_interim       (MSAD_interim),
        .MSAD_index_interim (MSAD_index_interim),
        .blk_advance        (blk_advance),
        .busy               (busy),
        .mv_valid           (mv_valid),
        .mv_ready           (mv_ready),
        .mv_sad             (mv_sad),
        .mv_batch           (mv_batch),
        .mv_index           (mv_index),
        .blk_x              (blk_x),
        .blk_y              (blk_y),
        .frame_done         (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (blk_advance === 1'b1) adv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Best candidate by the "strictly smaller wins, scan in batch order" rule; also where the search stops.
    function automatic void model(output int es, output int eb, output int ei, output int last_b);
        es = 1 << 30;
        eb = 0;
        ei = 0;
        last_b = NB - 1;
        for (int b = 0; b < NB; b++) begin
            if (sad_v[b] < es) begin
                es = sad_v[b];
                eb = b;
                ei = idx_v[b];
            end
`ifdef ME_EARLY_TERM_EN
            if (es <= EARLY_TERM_THR) begin
                last_b = b;
                break;
            end
`endif
        end
    endfunction

    task automatic fill_rand(input int lo, input int hi);
        for (int b = 0; b < NB; b++) begin
            sad_v[b] = $urandom_range(hi, lo);
            idx_v[b] = $urandom_range(15, 0);
        end
    endtask

    task automatic drive_for(input int b);
        if (b >= 0 && b < NB) begin
            MSAD_interim       = 14'(sad_v[b]);
            MSAD_index_interim = 4'(idx_v[b]);
        end else begin
            MSAD_interim       = 14'($urandom_range(16383, 0));
            MSAD_index_interim = 4'($urandom_range(15, 0));
        end
    endtask

    task automatic do_start(input bit with_sram);
        start      = 1'b1;
        sram_ready = with_sram;
        @(posedge clk); #1;
        start      = 1'b0;
        sram_ready = 1'b0;
        exp_x = 0;
        exp_y = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_block(input int hold, input bit ready_early, input bit poke);
        int es, eb, ei, lb, lat;
        bit last;
        model(es, eb, ei, lb);
        lat = PL + lb + 1;
        chk("blk_x_pre", blk_x, exp_x);
        chk("blk_y_pre", blk_y, exp_y);
        mv_ready   = ready_early;
        sram_ready = 1'b1;
        for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            sram_ready = 1'b0;
            drive_for(n - PL);
            chk("mv_valid_timing", mv_valid, (n == lat) ? 1 : 0);
            if (n < lat) chk("no_adv_in_search", blk_advance, 0);
        end
        chk("mv_sad", mv_sad, es);
        chk("mv_batch", mv_batch, eb);
        chk("mv_index", mv_index, ei);
        for (int h = 0; h < hold; h++) begin
            start      = poke && (h == 1);
            sram_ready = poke && (h == 1);
            @(posedge clk); #1;
            start      = 1'b0;
            sram_ready = 1'b0;
            drive_for(-1);
            chk("hold_valid", mv_valid, 1);
            chk("hold_sad", mv_sad, es);
            chk("hold_batch", mv_batch, eb);
            chk("hold_index", mv_index, ei);
            chk("hold_no_adv", blk_advance, 0);
        end
        mv_ready = 1'b1;
        @(posedge clk); #1;
        mv_ready = 1'b0;
        last = (exp_x == BPR - 1) && (exp_y == BR - 1);
        exp_adv++;
        if (last) begin
            exp_x = 0;
            exp_y = 0;
        end else if (exp_x == BPR - 1) begin
            exp_x = 0;
            exp_y++;
        end else begin
            exp_x++;
        end
        chk("adv_pulse", blk_advance, 1);
        chk("frame_done", frame_done, last ? 1 : 0);
        chk("valid_dropped", mv_valid, 0);
        chk("busy_post", busy, last ? 0 : 1);
        chk("blk_x_post", blk_x, exp_x);
        chk("blk_y_post", blk_y, exp_y);
        @(posedge clk); #1;
        chk("adv_one_cycle", blk_advance, 0);
        chk("frame_done_one_cycle", frame_done, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sram_ready = 1'b0;
        mv_ready = 1'b0;
        MSAD_interim = '0;
        MSAD_index_interim = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mv_valid", mv_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_blk_advance", blk_advance, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_mv_sad", mv_sad, 0);
        chk("rst_blk_x", blk_x, 0);
        chk("rst_blk_y", blk_y, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // start with simultaneous sram_ready: the sram_ready must not kick off a search
        do_start(1'b1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_search_from_start_sram", mv_valid, 0);
        end

        // block (0,0): directed minimum at batch 3
        for (int b = 0; b < NB; b++) begin
            sad_v[b] = 900;
            idx_v[b] = $urandom_range(15, 0);
        end
        sad_v[0] = 500;
        sad_v[1] = 400;
        sad_v[2] = 400;
        sad_v[3] = 300;
        idx_v[3] = 7;
        run_block(3, 1'b0, 1'b0);

        // block (1,0): all ties, stalled consumer, start/sram_ready poked during REPORT
        for (int b = 0; b < NB; b++) begin
            sad_v[b] = 1000;
            idx_v[b] = $urandom_range(15, 0);
        end
        run_block(5, 1'b0, 1'b1);

        // remaining four blocks with mv_ready held high throughout
        for (int k = 0; k < 4; k++) begin
            fill_rand(1, 16320);
            run_block(0, 1'b1, 1'b0);
        end
        @(posedge clk); #1;
        chk("frame1_idle_busy", busy, 0);
        chk("frame1_adv_count", adv_cnt, 6);

        // second frame: zero SAD at batch 2
        do_start(1'b0);
        fill_rand(1, 16320);
        sad_v[2] = 0;
        run_block(1, 1'b0, 1'b0);

        // abort mid-search at batch 5 with small SADs that must not leak into the next block
        for (int b = 0; b < NB; b++) begin
            sad_v[b] = 10 + b;
            idx_v[b] = $urandom_range(15, 0);
        end
        sram_ready = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            sram_ready = 1'b0;
            drive_for(n - PL);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_mv_valid", mv_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_blk_x", blk_x, 0);
        chk("abort_blk_y", blk_y, 0);
        chk("abort_mv_sad", mv_sad, 0);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_no_adv", adv_cnt, exp_adv);
        rst = 1'b0;
        @(posedge clk); #1;

        do_start(1'b0);
        fill_rand(2000, 16000);
        run_block(2, 1'b0, 1'b0);

        // tie-heavy random blocks
        for (int k = 0; k < 2; k++) begin
            fill_rand(100, 103);
            run_block($urandom_range(3, 0), 1'b0, 1'b0);
        end
        chk("adv_total", adv_cnt, exp_adv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
